zle_xc4_fsm: RTL and testbench

Control FSM that sequences the zero run-length encoder datapath (ZLE DP, 3-bit input stream, 4-bit output stream).
- Drives the DP's 4-bit state code and consumes its three flags.
- Owns all stream handshakes: input consume and output valid/backpressure. The DP itself fires unconditionally on whatever state it is given.
- Instantiated beside the DP in the ZLE top; the two together form the complete encoder.

---
 rtl/zle_pkg.sv | 25 ++
 rtl/zle_stat_cnt.sv | 28 ++
 rtl/zle_xc4_fsm.sv | 139 +++++++++++++
 tb/tb_zle_xc4_fsm.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zle_pkg.sv
// Shared definitions for the zero run-length encoder (ZLE).
// Holds the state codes driven from the control FSM to the datapath,
// the state-code width, and the input/output token widths.
// Codes 10-15 are illegal. Code 9 (DONE) is legal only when the
// end-of-stream feature (ZLE_EOS_EN) is compiled in.
package zle_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned I_W     = 3;
  localparam int unsigned O_W     = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_START     = 4'd0,
    ST_START_T   = 4'd1,
    ST_START_E   = 4'd2,
    ST_ZEROS     = 4'd3,
    ST_ZEROS_T   = 4'd4,
    ST_ZEROS_T_T = 4'd5,
    ST_ZEROS_T_E = 4'd6,
    ST_ZEROS_E   = 4'd7,
    ST_PENDING   = 4'd8,
    ST_DONE      = 4'd9
  } zle_state_e;

endpackage

// File: rtl/zle_stat_cnt.sv
// Wrapping statistics counter with an increment enable.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset (clears count)
//   inc_i   - add one this cycle
//   cnt_o   - current count; wraps modulo 2^W
module zle_stat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/zle_xc4_fsm.sv
// Control FSM for the ZLE datapath (3-bit tokens in, 4-bit tokens out).
// Sequences the DP through its state codes, owns the input consume and
// output valid/backpressure handshakes, and counts consumed/emitted tokens.
// Optional feature macro: ZLE_EOS_EN adds input i_eos and the DONE state.
// Ports:
//   clock, reset          - clock, asynchronous active-low reset
//   i_v / i_r             - input token present / consume (i_r from state)
//   i_eos                 - end-of-stream marker, qualified by i_v (ZLE_EOS_EN)
//   o_v / o_b             - output token valid (from state) / backpressure
//   f_start_i_eq_0        - DP flag i_d==0, honoured only in START
//   f_zeros_i_eq_0        - DP flag i_d==0, honoured only in ZEROS
//   f_zeros_t_cnt_eq_15   - DP flag run counter==15, honoured only in ZEROS_T
//   state                 - state code to DP
//   n_fire / n_emit       - consumed / accepted token counts, wrapping
module zle_xc4_fsm
  import zle_pkg::*;
#(
  parameter int unsigned FIRE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_v,
`ifdef ZLE_EOS_EN
  input  logic                i_eos,
`endif
  output logic                i_r,
  output logic                o_v,
  input  logic                o_b,
  input  logic                f_start_i_eq_0,
  input  logic                f_zeros_i_eq_0,
  input  logic                f_zeros_t_cnt_eq_15,
  output logic [STATE_W-1:0]  state,
  output logic [FIRE_W-1:0]   n_fire,
  output logic [FIRE_W-1:0]   n_emit
);

  // Kept as a plain vector so illegal codes are representable and recoverable.
  logic [STATE_W-1:0] state_q, state_d;

`ifdef ZLE_EOS_EN
  // Remembers that the run now being flushed was closed by end-of-stream.
  logic eos_q, eos_d;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_START;
`ifdef ZLE_EOS_EN
      eos_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ZLE_EOS_EN
      eos_q   <= eos_d;
`endif
    end
  end

  // Next state and handshake outputs; i_r and o_v are never both high.
  always_comb begin
    state_d = state_q;
    i_r     = 1'b0;
    o_v     = 1'b0;
`ifdef ZLE_EOS_EN
    eos_d   = eos_q;
`endif
    case (state_q)
      ST_START: begin
        i_r = i_v;
        if (i_v) begin
          state_d = f_start_i_eq_0 ? ST_START_T : ST_START_E;
`ifdef ZLE_EOS_EN
          if (i_eos) state_d = ST_DONE;
`endif
        end
      end
      ST_START_T: state_d = ST_ZEROS;
      ST_START_E: begin
        o_v = 1'b1;
        if (!o_b) state_d = ST_START;
      end
      ST_ZEROS: begin
        i_r = i_v;
        if (i_v) begin
          state_d = f_zeros_i_eq_0 ? ST_ZEROS_T : ST_ZEROS_E;
`ifdef ZLE_EOS_EN
          // End-of-stream flushes the open run as a token, no literal follows.
          if (i_eos) begin
            state_d = ST_ZEROS_E;
            eos_d   = 1'b1;
          end
`endif
        end
      end
      ST_ZEROS_T:   state_d = f_zeros_t_cnt_eq_15 ? ST_ZEROS_T_T : ST_ZEROS_T_E;
      ST_ZEROS_T_E: state_d = ST_ZEROS;
      ST_ZEROS_T_T: begin
        // Capped run emitted; the current zero opens a fresh run.
        o_v = 1'b1;
        if (!o_b) state_d = ST_START_T;
      end
      ST_ZEROS_E: begin
        o_v = 1'b1;
        if (!o_b) begin
          state_d = ST_PENDING;
`ifdef ZLE_EOS_EN
          if (eos_q) state_d = ST_DONE;
`endif
        end
      end
      ST_PENDING: begin
        o_v = 1'b1;
        if (!o_b) state_d = ST_START;
      end
`ifdef ZLE_EOS_EN
      ST_DONE: state_d = ST_DONE;
`endif
      default: state_d = ST_START;
    endcase
  end

  assign state = state_q;

  zle_stat_cnt #(.W(FIRE_W)) u_fire_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (i_v & i_r),
    .cnt_o  (n_fire)
  );

  zle_stat_cnt #(.W(FIRE_W)) u_emit_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (o_v & ~o_b),
    .cnt_o  (n_emit)
  );

endmodule

// File: tb/tb_zle_xc4_fsm.sv
// Directed bench for zle_xc4_fsm with a small behavioural ZLE datapath beside
// it. Expected tokens come from an independent run-length encoding model and
// are queued as each input token is consumed, then compared on acceptance.
module tb_zle_xc4_fsm;

  localparam int unsigned FIRE_W = 16;

  logic        clock;
  logic        reset;
  logic        i_v;
  logic [2:0]  i_d;
`ifdef ZLE_EOS_EN
  logic        i_eos;
`endif
  logic        i_r;
  logic        o_v;
  logic        o_b;
  logic        f_start_i_eq_0;
  logic        f_zeros_i_eq_0;
  logic        f_zeros_t_cnt_eq_15;
  logic [3:0]  state;
  logic [FIRE_W-1:0] n_fire;
  logic [FIRE_W-1:0] n_emit;

  zle_xc4_fsm #(.FIRE_W(FIRE_W)) dut (
    .clock               (clock),
    .reset               (reset),
    .i_v                 (i_v),
`ifdef ZLE_EOS_EN
    .i_eos               (i_eos),
`endif
    .i_r                 (i_r),
    .o_v                 (o_v),
    .o_b                 (o_b),
    .f_start_i_eq_0      (f_start_i_eq_0),
    .f_zeros_i_eq_0      (f_zeros_i_eq_0),
    .f_zeros_t_cnt_eq_15 (f_zeros_t_cnt_eq_15),
    .state               (state),
    .n_fire              (n_fire),
    .n_emit              (n_emit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural datapath: literal register and run counter keyed by state code.
  logic [2:0] dp_lit;
  logic [3:0] dp_cnt;
  logic [3:0] o_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dp_lit <= '0;
      dp_cnt <= '0;
    end else begin
      case (state)
        4'd0: if (i_v) dp_lit <= i_d;
        4'd1: dp_cnt <= 4'd1;
        4'd3: if (i_v) dp_lit <= i_d;
        4'd6: dp_cnt <= dp_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  assign o_d = (state == 4'd2 || state == 4'd8) ? {1'b0, dp_lit} : dp_cnt;
  assign f_start_i_eq_0      = (i_d == 3'd0);
  assign f_zeros_i_eq_0      = (i_d == 3'd0);
  assign f_zeros_t_cnt_eq_15 = (dp_cnt == 4'd15);

  int checks = 0;
  int errors = 0;
  int exp_fire = 0;
  int exp_emit = 0;
  int run_len = 0;
  int tt_visits = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference encoder: runs of zeros capped at 15, nonzero literals pass through.
  task automatic model(input logic [2:0] d, input bit eos);
    if (eos) begin
      if (run_len > 0) begin exp_q.push_back(run_len); exp_emit++; end
      run_len = 0;
    end else if (d == 3'd0) begin
      if (run_len == 15) begin
        exp_q.push_back(15); exp_emit++;
        run_len = 1;
      end else begin
        run_len++;
      end
    end else begin
      if (run_len > 0) begin exp_q.push_back(run_len); exp_emit++; end
      run_len = 0;
      exp_q.push_back(32'(d)); exp_emit++;
    end
  endtask

  // Offer one token; returns at posedge+1 right after the consuming edge.
  task automatic send(input logic [2:0] d, input bit eos);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    i_v = 1'b1;
    i_d = d;
`ifdef ZLE_EOS_EN
    i_eos = eos;
`endif
    while (!got && n < 200) begin
      @(negedge clock);
      got = i_r;
      @(posedge clock); #1;
      n++;
    end
    i_v = 1'b0;
    i_d = 3'd0;
`ifdef ZLE_EOS_EN
    i_eos = 1'b0;
`endif
    if (got) begin
      exp_fire++;
      model(d, eos);
    end else begin
      chk("send_timeout", 32'(got), 32'd1);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drain(input string tag);
    cycles(8);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_n_fire"}, 32'(n_fire), 32'(exp_fire));
    chk({tag, "_n_emit"}, 32'(n_emit), 32'(exp_emit));
  endtask

  // Scoreboard: compare each accepted token against the queued expectation.
  always @(negedge clock) begin
    if (reset) begin
      if (o_v && i_r) chk("vr_exclusive", 32'd1, 32'd0);
      if (state == 4'd5 && !o_b) tt_visits++;
      if (o_v && !o_b) begin
        if (exp_q.size() == 0) chk("unexpected_token", 32'(o_d), 32'd99);
        else chk("token", 32'(o_d), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0;
    i_v = 1'b0;
    i_d = 3'd0;
`ifdef ZLE_EOS_EN
    i_eos = 1'b0;
`endif
    o_b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_i_r", 32'(i_r), 32'd0);
    chk("rst_o_v", 32'(o_v), 32'd0);
    chk("rst_n_fire", 32'(n_fire), 32'd0);
    chk("rst_n_emit", 32'(n_emit), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // Single literal: START -> START_E -> START.
    send(3'd5, 1'b0);
    chk("lit_state_e", 32'(state), 32'd2);
    @(negedge clock);
    chk("lit_o_v", 32'(o_v), 32'd1);
    @(posedge clock); #1;
    chk("lit_state_back", 32'(state), 32'd0);
    drain("lit");

    // Run of three zeros then literal 7.
    send(3'd0, 1'b0); send(3'd0, 1'b0); send(3'd0, 1'b0); send(3'd7, 1'b0);
    drain("run");

    // Run cap: 17 zeros then 3 -> tokens 15, 2, 3.
    tt_visits = 0;
    for (int k = 0; k < 17; k++) send(3'd0, 1'b0);
    send(3'd3, 1'b0);
    drain("cap");
    chk("cap_tt_visits", 32'(tt_visits), 32'd1);

    // Backpressure held in ZEROS_E for 5 cycles.
    o_b = 1'b1;
    send(3'd0, 1'b0);
    send(3'd6, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_state", 32'(state), 32'd7);
      chk("bp_o_v", 32'(o_v), 32'd1);
      chk("bp_i_r", 32'(i_r), 32'd0);
      @(posedge clock); #1;
    end
    o_b = 1'b0;
    drain("bp");

    // Idle input in ZEROS with run length 4, then one more zero -> 5.
    for (int k = 0; k < 4; k++) send(3'd0, 1'b0);
    cycles(2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("idle_state", 32'(state), 32'd3);
      chk("idle_i_r", 32'(i_r), 32'd0);
      @(posedge clock); #1;
    end
    send(3'd0, 1'b0);
    send(3'd1, 1'b0);
    drain("idle");

    // Asynchronous reset while in ZEROS_T_E discards the partial run.
    send(3'd0, 1'b0);
    send(3'd0, 1'b0);
    cycles(1);
    chk("pre_rst_state", 32'(state), 32'd6);
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_i_r", 32'(i_r), 32'd0);
    chk("arst_o_v", 32'(o_v), 32'd0);
    chk("arst_n_fire", 32'(n_fire), 32'd0);
    chk("arst_n_emit", 32'(n_emit), 32'd0);
    exp_q.delete();
    run_len = 0;
    exp_fire = 0;
    exp_emit = 0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    send(3'd4, 1'b0);
    drain("post_rst");

`ifdef ZLE_EOS_EN
    // End of stream inside a run: flush run token, then hold DONE.
    send(3'd0, 1'b0);
    send(3'd0, 1'b0);
    send(3'd0, 1'b1);
    drain("eos");
    chk("eos_state", 32'(state), 32'd9);
    i_v = 1'b1;
    i_d = 3'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("done_state", 32'(state), 32'd9);
      chk("done_i_r", 32'(i_r), 32'd0);
      chk("done_o_v", 32'(o_v), 32'd0);
      @(posedge clock); #1;
    end
    i_v = 1'b0;
    chk("done_n_fire", 32'(n_fire), 32'(exp_fire));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
